id_ex_stage: RTL

Decode-to-execute pipeline stage on the read side of the 16x16 register file. It decodes the fetched instruction into the two source register indices and drives them into the register file. It patches the file's missing write-before-read bypass from the writeback port and detects load-use hazards. The operands and control are latched into the ID/EX pipeline register with stall, flush and halt handling.

---
 rtl/wisc_pkg.sv | 37 +++
 rtl/src_bypass.sv | 13 +
 rtl/id_ex_stage.sv | 99 +++++++++
 3 files changed

// File: rtl/wisc_pkg.sv
// wisc_pkg: shared ISA opcodes, ID/EX stage state encoding and pipeline register layout
package wisc_pkg;
  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;
  localparam logic [3:0] REG_ZERO  = 4'h0;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_BUBBLE = 2'd1, ST_HALTED = 2'd2} state_t;
  typedef struct packed {
    logic        valid;
    logic [3:0]  opcode;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic [3:0]  rd;
    logic        write;
    logic        mem_read;
    logic        mem_write;
    logic        halt;
    logic [15:0] pc;
  } ex_t;
  function automatic logic writes_rd(input logic [3:0] op);
    return !op[3] || op == OP_LW || op == OP_LLB || op == OP_LHB || op == OP_PCS;
  endfunction
endpackage

// File: rtl/src_bypass.sv
// src_bypass: register-file read patch with writeback bypass; index 0 always reads zero
module src_bypass
  import wisc_pkg::*;
(
  input  logic [3:0]  idx,
  input  logic [15:0] rf_data,
  input  logic        wb_write,
  input  logic [3:0]  wb_reg,
  input  logic [15:0] wb_data,
  output logic [15:0] data
);
  assign data = idx == REG_ZERO ? 16'h0000 : (wb_write && wb_reg == idx) ? wb_data : rf_data;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode, operand read with wb bypass, load-use bubble and ID/EX register
module id_ex_stage
  import wisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [15:0] id_instr,
  input  logic [15:0] id_pc,
  output logic [3:0]  SrcReg1,
  output logic [3:0]  SrcReg2,
  input  logic [15:0] SrcData1,
  input  logic [15:0] SrcData2,
  input  logic        wb_write,
  input  logic [3:0]  wb_reg,
  input  logic [15:0] wb_data,
  input  logic        flush,
  input  logic        ex_stall,
  output logic        id_stall,
  output logic        ex_valid,
  output logic [3:0]  ex_opcode,
  output logic [15:0] ex_a,
  output logic [15:0] ex_b,
  output logic [15:0] ex_imm,
  output logic [3:0]  ex_rd,
  output logic        ex_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_halt,
  output logic [15:0] ex_pc
);
  logic [3:0] op, rd, rs, rt;
  logic [15:0] op_a, op_b;
  logic use1, use2, hz, halted;
  state_t state, state_n;
  ex_t ex, ex_n, cap, bub;
  assign op = id_instr[15:12];
  assign rd = id_instr[11:8];
  assign rs = id_instr[7:4];
  assign rt = id_instr[3:0];
  assign SrcReg1 = (op == OP_LLB || op == OP_LHB) ? rd : rs;
  assign SrcReg2 = op == OP_SW ? rd : rt;
  src_bypass u_byp1 (.idx(SrcReg1), .rf_data(SrcData1), .wb_write(wb_write), .wb_reg(wb_reg), .wb_data(wb_data), .data(op_a));
  src_bypass u_byp2 (.idx(SrcReg2), .rf_data(SrcData2), .wb_write(wb_write), .wb_reg(wb_reg), .wb_data(wb_data), .data(op_b));
  // Only the source fields an opcode actually reads can create a load-use hazard
  assign use1 = !op[3] || op == OP_LW || op == OP_SW || op == OP_LLB || op == OP_LHB || op == OP_BR;
  assign use2 = !op[3] || op == OP_SW;
  assign halted = state == ST_HALTED;
  assign hz = rst && !halted && id_valid && ex.valid && ex.mem_read && ex.rd != REG_ZERO &&
              ((use1 && ex.rd == SrcReg1) || (use2 && ex.rd == SrcReg2));
  assign id_stall = ex_stall || (hz && !flush) || (rst && halted);
  always_comb begin
    cap = '0;
    cap.valid = id_valid;
    cap.opcode = op;
    cap.a = op_a;
    cap.b = op_b;
    cap.imm = {8'h00, id_instr[7:0]};
    cap.rd = rd;
    cap.write = id_valid && writes_rd(op) && rd != REG_ZERO;
    cap.mem_read = id_valid && op == OP_LW;
    cap.mem_write = id_valid && op == OP_SW;
    cap.halt = id_valid && op == OP_HLT;
    cap.pc = id_pc;
    bub = ex;
    bub.valid = 1'b0;
    bub.write = 1'b0;
    bub.mem_read = 1'b0;
    bub.mem_write = 1'b0;
    bub.halt = 1'b0;
    ex_n = (flush || (!ex_stall && (hz || halted))) ? bub : ex_stall ? ex : cap;
    // HALTED is left only through reset
    state_n = flush ? (halted ? ST_HALTED : ST_RUN) :
              ex_stall ? state :
              hz ? ST_BUBBLE :
              halted ? ST_HALTED :
              cap.halt ? ST_HALTED : ST_RUN;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex <= '0;
      state <= ST_RUN;
    end else begin
      ex <= ex_n;
      state <= state_n;
    end
  end
  assign ex_valid = ex.valid;
  assign ex_opcode = ex.opcode;
  assign ex_a = ex.a;
  assign ex_b = ex.b;
  assign ex_imm = ex.imm;
  assign ex_rd = ex.rd;
  assign ex_write = ex.write;
  assign ex_mem_read = ex.mem_read;
  assign ex_mem_write = ex.mem_write;
  assign ex_halt = ex.halt;
  assign ex_pc = ex.pc;
endmodule
